ddc_decim_cfg_seq: RTL and testbench
====================================

// Module: ddc_decim_cfg_seq
// PURPOSE
//   Sequencer that turns one requested DDC decimation rate into the halfband/CIC split and the two register writes.
//   Sits between the DDC control path and rfnoc_block_ddc's ctrlport register space.
//   - Factors out up to NUM_HB powers of two (one per cycle).
//   - Range-checks the CIC remainder.
//   - Waits for the datapath to go idle, then writes SR_N_ADDR followed by SR_DECIM_ADDR, each with an ack handshake.
// PARAMETERS
//   NUM_HB         3      halfband stages present in the DDC (1..3)
//   CIC_MAX_DECIM  255    largest legal CIC rate (<=255)
//   DECIM_W        12     width of requested decimation rate
//   N_ADDR         20'h0  byte address written with full decim rate
//   DECIM_ADDR     20'h0  byte address written with {hb_en,cic_rate}
//   ACK_TIMEOUT    255    cycles to wait for wr_ack before error (>=1)
// PORTS
//   ce_clk        in   1        clock; all logic is on this edge
//   ce_rst        in   1        synchronous active-high reset
//   req_valid     in   1        configuration request
//   req_ready     out  1        high only in IDLE
//   req_decim     in   DECIM_W  requested decimation rate
//   dp_idle       in   1        DDC has no packet in flight
//   wr_req        out  1        one-cycle write strobe
//   wr_addr       out  20       write byte address
//   wr_data       out  32       write data
//   wr_ack        in   1        write completion
//   done          out  1        one-cycle pulse: config applied
//   err           out  1        one-cycle pulse: rejected or ack timeout
//   err_code      out  2        0 none, 1 decim==0, 2 CIC out of range, 3 ack timeout
//   hb_en         out  2        last accepted halfband count
//   cic_rate      out  8        last accepted CIC rate
// BEHAVIOUR
//   Reset values: all outputs 0 except req_ready=1; state IDLE; timeout counter 0.
//   IDLE
//     - req_valid&&req_ready captures req_decim into rem; hb_cnt=0.
//     - Next state is FACTOR, or ERR(code 1) if req_decim==0.
//   FACTOR
//     - Each cycle while rem[0]==0 && hb_cnt<NUM_HB: rem>>=1, hb_cnt++.
//     - Otherwise go to CHECK. Latency is hb_cnt+1 cycles.
//   CHECK
//     - rem>CIC_MAX_DECIM -> ERR(code 2). No writes are issued and hb_en/cic_rate are unchanged.
//     - Else -> WAIT_IDLE.
//   WAIT_IDLE
//     - Hold while dp_idle==0; no timeout applies here.
//     - On dp_idle==1 -> WR_N.
//   WR_N
//     - wr_req=1 for exactly one cycle; wr_addr=N_ADDR; wr_data=zero-extended decim; -> ACK_N.
//   ACK_N
//     - Counter counts cycles. wr_ack -> WR_DEC.
//     - Counter reaching ACK_TIMEOUT without ack -> ERR(code 3).
//   WR_DEC
//     - wr_req=1 for one cycle; wr_addr=DECIM_ADDR; wr_data={22'b0,hb_cnt[1:0],rem[7:0]}; -> ACK_DEC.
//   ACK_DEC
//     - wr_ack: latch hb_en/cic_rate, done=1 for one cycle -> IDLE.
//     - Timeout -> ERR(code 3).
//   ERR
//     - err=1 for one cycle with err_code valid -> IDLE.
//     - err_code holds its value until the next request is accepted.
//   Handshake and output rules
//     - wr_addr/wr_data stay stable from the strobe until ack.
//     - wr_ack outside ACK_* states is ignored.
//     - wr_ack in the same cycle as wr_req is not accepted; ack is sampled from the next cycle.
//     - req_valid outside IDLE is not accepted (req_ready=0); the requester holds it.
//   Boundaries
//     - decim=1 gives hb 0, cic 1.
//     - Max DECIM_W value: cic = value>>NUM_HB (after factoring), range-checked.
//     - Timeout counter clears on entry to each ACK state.
//   ce_rst mid-operation
//     - Returns to IDLE next cycle. An outstanding write is abandoned with no further strobe.
//     - hb_en/cic_rate reset to 0.
// STRUCTURE
//   Shared package ddc_cfg_pkg:
//     - typedef enum state_t {IDLE,FACTOR,CHECK,WAIT_IDLE,WR_N,ACK_N,WR_DEC,ACK_DEC,ERR}
//     - err_code_t constants
//     - DECIM_FIELD packing function {hb,cic}
//   Single flat module; no sub-module. FSM plus datapath registers rem, hb_cnt, tmo_cnt.
// TESTING
//   1. Decim 40, dp_idle=1, ack after 2 cycles.
//      -> writes (N_ADDR,40), then (DECIM_ADDR,0x305); done; hb_en=3, cic_rate=5.
//   2. Decim 1, then 2040.
//      -> data 0x001 then 0x3FF.
//   3. Decim 12, then 13.
//      -> 0x203 and 0x00D. Factoring takes 3 and 1 cycles respectively.
//   4. Decim 257, then 0.
//      -> err_code 2 then 1. No wr_req ever asserted; hb_en/cic_rate unchanged.
//   5. dp_idle held low 50 cycles.
//      -> no wr_req until dp_idle rises; first strobe 1 cycle after the rise.
//   6. wr_ack withheld (ACK_TIMEOUT=8).
//      -> err_code 3 after 8 cycles in ACK_N; no DECIM write.
//   7. Reset mid-operation: ce_rst asserted during ACK_DEC.
//      -> IDLE, req_ready=1, outputs 0 next cycle; a following request completes normally.

Source files
------------

// File: rtl/ddc_decim_cfg_seq_pkg.sv
// Shared types and helpers for the DDC decimation configuration sequencer.
package ddc_cfg_pkg;

   // Sequencer states.
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FACTOR    = 4'd1,
      CHECK     = 4'd2,
      WAIT_IDLE = 4'd3,
      WR_N      = 4'd4,
      ACK_N     = 4'd5,
      WR_DEC    = 4'd6,
      ACK_DEC   = 4'd7,
      ERR       = 4'd8
   } state_t;

   // Error reasons reported on err_code.
   typedef logic [1:0] err_code_t;
   localparam err_code_t ERR_NONE    = 2'd0;
   localparam err_code_t ERR_ZERO    = 2'd1;
   localparam err_code_t ERR_RANGE   = 2'd2;
   localparam err_code_t ERR_TIMEOUT = 2'd3;

   // Packs the halfband count and CIC rate into the decimation register word.
   function automatic logic [31:0] decim_field(input logic [1:0] hb, input logic [7:0] cic);
      return {22'd0, hb, cic};
   endfunction

endpackage

// File: rtl/ddc_decim_cfg_seq.sv
// Turns a requested DDC decimation rate into a halfband/CIC split, range-checks
// the CIC part, waits for the datapath to drain and issues the two register
// writes (full rate, then {hb_en,cic_rate}) with ack handshakes and timeouts.
// DECIM_W must lie in 8..32 so the CIC field and the rate word both fit.
module ddc_decim_cfg_seq
   import ddc_cfg_pkg::*;
#(
   parameter int          NUM_HB        = 3,
   parameter int          CIC_MAX_DECIM = 255,
   parameter int          DECIM_W       = 12,
   parameter logic [19:0] N_ADDR        = 20'h0,
   parameter logic [19:0] DECIM_ADDR    = 20'h0,
   parameter int          ACK_TIMEOUT   = 255
) (
   input  logic               ce_clk,
   input  logic               ce_rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [DECIM_W-1:0] req_decim,
   input  logic               dp_idle,
   output logic               wr_req,
   output logic [19:0]        wr_addr,
   output logic [31:0]        wr_data,
   input  logic               wr_ack,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [1:0]         hb_en,
   output logic [7:0]         cic_rate
);

   localparam int                 TMO_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [1:0]         HB_LIM   = 2'(NUM_HB);
   localparam logic [DECIM_W-1:0] CIC_LIM  = DECIM_W'(CIC_MAX_DECIM);

   state_t             state, state_nxt;
   logic [DECIM_W-1:0] rem, rem_nxt;
   logic [DECIM_W-1:0] decim, decim_nxt;
   logic [1:0]         hb_cnt, hb_cnt_nxt;
   logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
   logic [19:0]        wr_addr_nxt;
   logic [31:0]        wr_data_nxt;
   err_code_t          err_code_nxt;
   logic [1:0]         hb_en_nxt;
   logic [7:0]         cic_rate_nxt;
   logic               done_nxt;

   // Next-state and next-register decode; every register holds unless its state says otherwise.
   always_comb begin
      state_nxt    = state;
      rem_nxt      = rem;
      decim_nxt    = decim;
      hb_cnt_nxt   = hb_cnt;
      tmo_cnt_nxt  = tmo_cnt;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      err_code_nxt = err_code;
      hb_en_nxt    = hb_en;
      cic_rate_nxt = cic_rate;
      done_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               decim_nxt    = req_decim;
               rem_nxt      = req_decim;
               hb_cnt_nxt   = 2'd0;
               err_code_nxt = ERR_NONE;
               if (req_decim == '0) begin
                  state_nxt    = ERR;
                  err_code_nxt = ERR_ZERO;
               end else begin
                  state_nxt = FACTOR;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         FACTOR: begin
            // One power of two is peeled off per cycle, up to the halfband count.
            if (!rem[0] && (hb_cnt < HB_LIM)) begin
               rem_nxt    = rem >> 1;
               hb_cnt_nxt = hb_cnt + 2'd1;
            end else begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (rem > CIC_LIM) begin
               state_nxt    = ERR;
               err_code_nxt = ERR_RANGE;
            end else begin
               state_nxt = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (dp_idle) begin
               state_nxt   = WR_N;
               wr_addr_nxt = N_ADDR;
               wr_data_nxt = {{(32-DECIM_W){1'b0}}, decim};
            end else begin
               state_nxt = WAIT_IDLE;
            end
         end
         WR_N: begin
            // An ack coinciding with the strobe is deliberately not looked at here.
            state_nxt   = ACK_N;
            tmo_cnt_nxt = '0;
         end
         ACK_N: begin
            if (wr_ack) begin
               state_nxt   = WR_DEC;
               wr_addr_nxt = DECIM_ADDR;
               wr_data_nxt = decim_field(hb_cnt, rem[7:0]);
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt    = ERR;
               err_code_nxt = ERR_TIMEOUT;
            end else begin
               tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         WR_DEC: begin
            state_nxt   = ACK_DEC;
            tmo_cnt_nxt = '0;
         end
         ACK_DEC: begin
            if (wr_ack) begin
               state_nxt    = IDLE;
               hb_en_nxt    = hb_cnt;
               cic_rate_nxt = rem[7:0];
               done_nxt     = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt    = ERR;
               err_code_nxt = ERR_TIMEOUT;
            end else begin
               tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         ERR: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; strobes are decoded from the next state.
   always_ff @(posedge ce_clk) begin
      if (ce_rst) begin
         state     <= IDLE;
         rem       <= '0;
         decim     <= '0;
         hb_cnt    <= 2'd0;
         tmo_cnt   <= '0;
         req_ready <= 1'b1;
         wr_req    <= 1'b0;
         wr_addr   <= 20'd0;
         wr_data   <= 32'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         hb_en     <= 2'd0;
         cic_rate  <= 8'd0;
      end else begin
         state     <= state_nxt;
         rem       <= rem_nxt;
         decim     <= decim_nxt;
         hb_cnt    <= hb_cnt_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         req_ready <= (state_nxt == IDLE);
         wr_req    <= (state_nxt == WR_N) || (state_nxt == WR_DEC);
         wr_addr   <= wr_addr_nxt;
         wr_data   <= wr_data_nxt;
         done      <= done_nxt;
         err       <= (state_nxt == ERR);
         err_code  <= err_code_nxt;
         hb_en     <= hb_en_nxt;
         cic_rate  <= cic_rate_nxt;
      end
   end

endmodule

// File: tb/tb_ddc_decim_cfg_seq.sv
// Scoreboard bench for ddc_decim_cfg_seq: a driver issues requests and pushes
// the expected writes/done/err events; a negedge monitor pops and compares.
module tb_ddc_decim_cfg_seq;

   localparam int          NUM_HB = 3;
   localparam int          CICMAX = 255;
   localparam int          TMO    = 8;
   localparam logic [19:0] N_A    = 20'h00010;
   localparam logic [19:0] D_A    = 20'h00014;

   logic        clk;
   logic        ce_rst;
   logic        req_valid;
   logic        req_ready;
   logic [11:0] req_decim;
   logic        dp_idle;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ack;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [1:0]  hb_en;
   logic [7:0]  cic_rate;

   ddc_decim_cfg_seq #(
      .NUM_HB(NUM_HB), .CIC_MAX_DECIM(CICMAX), .DECIM_W(12),
      .N_ADDR(N_A), .DECIM_ADDR(D_A), .ACK_TIMEOUT(TMO)
   ) dut (
      .ce_clk(clk), .ce_rst(ce_rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_decim(req_decim), .dp_idle(dp_idle), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .done(done), .err(err), .err_code(err_code),
      .hb_en(hb_en), .cic_rate(cic_rate)
   );

   typedef struct {
      int          kind;   // 1 write, 2 done, 3 err
      logic [19:0] addr;
      logic [31:0] data;
      int          code;
      int          hb;
      int          cic;
      longint      t_abs;  // expected edge time, 0 = unchecked
      longint      t_rel;  // expected distance from previous strobe, 0 = unchecked
   } ev_t;

   ev_t    q[$];
   int     checks = 0;
   int     failures = 0;
   int     ack_delay = 1;
   int     ack_mode = 0;   // 0 ack both, 1 ack none, 2 ack only the N write
   bit     stray_en = 1'b0;
   int     model_hb = 0;
   int     model_cic = 0;
   longint last_strobe = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference split: strip up to NUM_HB factors of two from the rate.
   function automatic void model(input int d, output int hb, output int r);
      hb = 0;
      r  = d;
      while (d != 0 && (r % 2) == 0 && hb < NUM_HB) begin
         r  = r / 2;
         hb = hb + 1;
      end
   endfunction

   function automatic ev_t mk(input int kind, input logic [19:0] a, input logic [31:0] dat,
                              input int code, input longint t_abs, input longint t_rel);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = dat; e.code = code;
      e.hb = model_hb; e.cic = model_cic; e.t_abs = t_abs; e.t_rel = t_rel;
      return e;
   endfunction

   // Ack responder: acks a strobe ack_delay cycles later; optional stray ack in the strobe cycle.
   initial begin
      int cnt;
      cnt = -1;
      wr_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         wr_ack = 1'b0;
         if (ce_rst) cnt = -1;
         else if (wr_req) begin
            if (ack_mode == 0 || (ack_mode == 2 && wr_addr == N_A)) cnt = ack_delay;
            else cnt = -1;
            if (stray_en) wr_ack = 1'b1;
         end else if (cnt > 0) cnt--;
         if (cnt == 0) begin
            wr_ack = 1'b1;
            cnt = -1;
         end
      end
   end

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      ev_t e;
      longint te;
      te = $time - 5;
      if (!ce_rst) begin
         if (wr_req) begin
            if (q.size() == 0) check("unexpected_wr_req", 1, 0);
            else begin
               e = q.pop_front();
               check("wr_kind", e.kind, 1);
               check("wr_addr", wr_addr, e.addr);
               check("wr_data", wr_data, e.data);
               if (e.t_abs != 0) check("wr_time", te, e.t_abs);
               if (e.t_rel != 0) check("wr_gap", te - last_strobe, e.t_rel);
            end
            last_strobe = te;
         end
         if (done) begin
            if (q.size() == 0) check("unexpected_done", 1, 0);
            else begin
               e = q.pop_front();
               check("done_kind", e.kind, 2);
               check("done_hb_en", hb_en, e.hb);
               check("done_cic_rate", cic_rate, e.cic);
               if (e.t_rel != 0) check("done_gap", te - last_strobe, e.t_rel);
            end
         end
         if (err) begin
            if (q.size() == 0) check("unexpected_err", 1, 0);
            else begin
               e = q.pop_front();
               check("err_kind", e.kind, 3);
               check("err_code", err_code, e.code);
               check("err_hb_en_kept", hb_en, e.hb);
               check("err_cic_kept", cic_rate, e.cic);
               if (e.t_abs != 0) check("err_time", te, e.t_abs);
               if (e.t_rel != 0) check("err_gap", te - last_strobe, e.t_rel);
            end
         end
      end
   end

   // Issue one request and push its expected events; returns once they are all seen.
   task automatic run_req(input int d, input int hold, input int delay, input int mode, input bit stray);
      int hb, r, guard, ecode;
      longint a, ts;
      model(d, hb, r);
      ack_delay = delay;
      ack_mode  = mode;
      stray_en  = stray;
      dp_idle   = (hold == 0);
      req_decim = 12'(d);
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) begin
         check("req_ready_timeout", 0, 1);
         req_valid = 1'b0;
         dp_idle = 1'b1;
         return;
      end
      @(posedge clk);
      a = $time;
      #1 req_valid = 1'b0;
      ecode = 0;
      if (d == 0) begin
         ecode = 1;
         q.push_back(mk(3, 20'd0, 32'd0, 1, a, 0));
      end else if (r > CICMAX) begin
         ecode = 2;
         q.push_back(mk(3, 20'd0, 32'd0, 2, a + (hb + 2) * 10, 0));
      end else begin
         ts = a + (hb + 3) * 10;
         if (hold > 0) begin
            repeat (hold) @(posedge clk);
            if ($time + 10 > ts) ts = $time + 10;
            #1 dp_idle = 1'b1;
         end
         q.push_back(mk(1, N_A, 32'(d), 0, ts, 0));
         if (mode == 1) begin
            ecode = 3;
            q.push_back(mk(3, 20'd0, 32'd0, 3, 0, (TMO + 1) * 10));
         end else begin
            q.push_back(mk(1, D_A, 32'(hb * 256 + r), 0, 0, (delay + 1) * 10));
            if (mode == 0) begin
               model_hb  = hb;
               model_cic = r;
               q.push_back(mk(2, 20'd0, 32'd0, 0, 0, (delay + 1) * 10));
            end
         end
      end
      dp_idle = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 400) begin
         @(posedge clk); #1;
         guard++;
      end
      if (q.size() != 0) begin
         check("scoreboard_timeout", q.size(), 0);
         q.delete();
      end
      if (mode != 2) begin
         guard = 0;
         while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
         end
         check("back_to_idle", req_ready, 1);
         if (ecode != 0) begin
            @(posedge clk); #1;
            check("err_code_held", err_code, ecode);
         end
      end
   endtask

   initial begin
      int d, hold, mode;
      ce_rst = 1'b1;
      req_valid = 1'b0;
      req_decim = 12'd0;
      dp_idle = 1'b1;
      repeat (3) @(posedge clk);
      #1 ce_rst = 1'b0;
      check("rst_req_ready", req_ready, 1);
      check("rst_wr_req", wr_req, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_done_err", {done, err}, 0);
      check("rst_err_code", err_code, 0);
      check("rst_hb_cic", {hb_en, cic_rate}, 0);

      run_req(40, 0, 2, 0, 1'b0);     // 0x305
      check("hb_en_after_40", hb_en, 3);
      check("cic_after_40", cic_rate, 5);
      run_req(1, 0, 1, 0, 1'b1);      // 0x001
      run_req(2040, 0, 3, 0, 1'b0);   // 0x3FF
      run_req(12, 0, 1, 0, 1'b0);     // 0x203, 3 factor cycles
      run_req(13, 0, 4, 0, 1'b1);     // 0x00D, 1 factor cycle
      run_req(257, 0, 1, 0, 1'b0);    // range error
      run_req(0, 0, 1, 0, 1'b0);      // zero error
      run_req(4095, 0, 1, 0, 1'b0);   // max input, out of range
      run_req(4088, 0, 1, 0, 1'b0);   // 4088>>3 = 511, out of range
      run_req(100, 50, 2, 0, 1'b0);   // datapath busy for 50 cycles
      run_req(40, 0, 1, 1, 1'b0);     // ack withheld -> timeout

      // Reset while waiting for the second ack.
      run_req(40, 0, 2, 2, 1'b0);
      @(posedge clk); #1 ce_rst = 1'b1;
      @(posedge clk); #1 ce_rst = 1'b0;
      model_hb = 0;
      model_cic = 0;
      check("midrst_req_ready", req_ready, 1);
      check("midrst_strobes", {wr_req, done, err}, 0);
      check("midrst_wr_addr_data", {wr_addr, wr_data}, 0);
      check("midrst_hb_cic", {hb_en, cic_rate}, 0);
      check("midrst_err_code", err_code, 0);
      repeat (12) @(posedge clk);
      #1;
      run_req(96, 0, 2, 0, 1'b0);     // 0x30C

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: d = $urandom_range(0, 16);
            1: d = $urandom_range(0, 4095);
            default: d = $urandom_range(0, 255) << $urandom_range(0, 4);
         endcase
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
         mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
         run_req(d, hold, $urandom_range(1, 5), mode, 1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      check("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
